// File: rtl/game_pkg.sv
// Shared definitions for the round sequencer and the VGA renderer.
// Holds state codes, default box sizes, game timing and screen geometry.
// Pure definitions plus one clamp helper; no state.
package game_pkg;

  // The VGA renderer decodes these same codes from game_state.
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_WAIT_TARGET = 3'd1,
    ST_PLAYING     = 3'd2,
    ST_ROUND_WON   = 3'd3,
    ST_GAME_OVER   = 3'd4
  } game_state_e;

  localparam int PLAYER_HALF_DEF = 25;
  localparam int TARGET_HALF_DEF = 30;
  localparam int HOLD_FRAMES_DEF = 60;
  localparam int WIN_FRAMES_DEF  = 30;
  localparam int GAME_FRAMES_DEF = 1800;

  localparam int X_MAX_DEF = 639;
  localparam int Y_MAX_DEF = 479;
  localparam int X_CENTRE  = 320;
  localparam int Y_CENTRE  = 240;

  // Saturate v into [lo, hi]; assumes lo <= hi.
  function automatic logic [9:0] clamp10(input logic [9:0] v,
                                         input logic [9:0] lo,
                                         input logic [9:0] hi);
    logic [9:0] r;
    r = v;
    if (v < lo) begin
      r = lo;
    end else if (v > hi) begin
      r = hi;
    end
    return r;
  endfunction

endpackage

// File: rtl/game_round_controller_if.sv
// Signal bundle between the round sequencer and its neighbours
// (timing generator, target RNG, VGA renderer).
// master = sequencer side, slave = environment side.
interface game_round_controller_if;

  logic        screenEnd;
  logic        start;
  logic [31:0] accel_x;
  logic [31:0] accel_y;
  logic [9:0]  rand_x;
  logic [8:0]  rand_y;
  logic        rand_valid;

  logic        target_req;
  logic [31:0] target_x;
  logic [31:0] target_y;
  logic [31:0] game_state;
  logic [7:0]  score;
  logic [10:0] frames_left;
  logic [6:0]  hold_count;

  modport master (
    input  screenEnd, start, accel_x, accel_y, rand_x, rand_y, rand_valid,
    output target_req, target_x, target_y, game_state, score, frames_left, hold_count
  );

  modport slave (
    output screenEnd, start, accel_x, accel_y, rand_x, rand_y, rand_valid,
    input  target_req, target_x, target_y, game_state, score, frames_left, hold_count
  );

endinterface

// File: rtl/box_containment.sv
// Checks whether the player box lies fully inside the target box.
// Latency: purely combinational.
// Backpressure: none.
module box_containment
  import game_pkg::*;
#(
  parameter int PLAYER_HALF = PLAYER_HALF_DEF,
  parameter int TARGET_HALF = TARGET_HALF_DEF
) (
  input  logic [9:0] px,
  input  logic [9:0] py,
  input  logic [9:0] tx,
  input  logic [9:0] ty,
  output logic       contained
);

  // Centre offset allowed before an edge of the player crosses the target edge.
  localparam logic signed [10:0] SLACK = 11'(TARGET_HALF - PLAYER_HALF);

  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic signed [10:0] adx;
  logic signed [10:0] ady;

  // Signed 11-bit differences so a player left/above the target never wraps.
  always_comb begin
    dx        = $signed({1'b0, px}) - $signed({1'b0, tx});
    dy        = $signed({1'b0, py}) - $signed({1'b0, ty});
    adx       = dx[10] ? -dx : dx;
    ady       = dy[10] ? -dy : dy;
    contained = (adx <= SLACK) && (ady <= SLACK);
  end

endmodule

// File: rtl/game_round_controller.sv
// Frame-synchronous game sequencer: request target, check hold, score, run game timer.
// Latency: outputs register one clk_25mHz edge after frame tick / start edge / rand_valid.
// Backpressure: none; rand_valid consumed only in WAIT_TARGET, start only in IDLE/GAME_OVER.
module game_round_controller
  import game_pkg::*;
#(
  parameter int PLAYER_HALF = PLAYER_HALF_DEF,
  parameter int TARGET_HALF = TARGET_HALF_DEF,
  parameter int HOLD_FRAMES = HOLD_FRAMES_DEF,
  parameter int WIN_FRAMES  = WIN_FRAMES_DEF,
  parameter int GAME_FRAMES = GAME_FRAMES_DEF,
  parameter int X_MAX       = X_MAX_DEF,
  parameter int Y_MAX       = Y_MAX_DEF
) (
  input  logic clk_25mHz,
  input  logic reset,
  game_round_controller_if.master bus
);

  localparam int         WIN_W = $clog2(WIN_FRAMES + 1);
  localparam logic [9:0] X_LO  = 10'(TARGET_HALF);
  localparam logic [9:0] X_HI  = 10'(X_MAX - TARGET_HALF);
  localparam logic [9:0] Y_LO  = 10'(TARGET_HALF);
  localparam logic [9:0] Y_HI  = 10'(Y_MAX - TARGET_HALF);

  game_state_e      state_q, state_d;
  logic             screen_end_q, screen_end_d;
  logic             start_q, start_d;
  logic             target_req_q, target_req_d;
  logic [9:0]       target_x_q, target_x_d;
  logic [9:0]       target_y_q, target_y_d;
  logic [7:0]       score_q, score_d;
  logic [10:0]      frames_left_q, frames_left_d;
  logic [6:0]       hold_count_q, hold_count_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;

  logic       frame_tick;
  logic       start_edge;
  logic       contained;
  logic [6:0] hold_next;
  logic       unused_accel_hi;

  // Only the low position bits carry screen coordinates.
  assign unused_accel_hi = ^{bus.accel_x[31:10], bus.accel_y[31:9]};

  box_containment #(
    .PLAYER_HALF (PLAYER_HALF),
    .TARGET_HALF (TARGET_HALF)
  ) u_box (
    .px        (bus.accel_x[9:0]),
    .py        ({1'b0, bus.accel_y[8:0]}),
    .tx        (target_x_q),
    .ty        (target_y_q),
    .contained (contained)
  );

  // Next-state and next-output computation for the round FSM.
  always_comb begin
    frame_tick    = bus.screenEnd & ~screen_end_q;
    start_edge    = bus.start & ~start_q;

    screen_end_d  = bus.screenEnd;
    start_d       = bus.start;
    state_d       = state_q;
    target_req_d  = target_req_q;
    target_x_d    = target_x_q;
    target_y_d    = target_y_q;
    score_d       = score_q;
    frames_left_d = frames_left_q;
    hold_count_d  = hold_count_q;
    win_cnt_d     = win_cnt_q;
    hold_next     = contained ? (hold_count_q + 7'd1) : 7'd0;

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          score_d       = 8'd0;
          frames_left_d = 11'(GAME_FRAMES);
          hold_count_d  = 7'd0;
          target_req_d  = 1'b1;
          state_d       = ST_WAIT_TARGET;
        end
      end

      ST_WAIT_TARGET: begin
        if (bus.rand_valid) begin
          target_x_d   = clamp10(bus.rand_x, X_LO, X_HI);
          target_y_d   = clamp10({1'b0, bus.rand_y}, Y_LO, Y_HI);
          target_req_d = 1'b0;
          hold_count_d = 7'd0;
          state_d      = ST_PLAYING;
        end
      end

      ST_PLAYING: begin
        if (frame_tick) begin
          hold_count_d = hold_next;
          // A win outranks timer expiry; the timer then expires on the next playing tick.
          if (hold_next == 7'(HOLD_FRAMES)) begin
            score_d   = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
            win_cnt_d = '0;
            state_d   = ST_ROUND_WON;
          end else if (frames_left_q == 11'd1) begin
            frames_left_d = 11'd0;
            state_d       = ST_GAME_OVER;
          end else begin
            frames_left_d = frames_left_q - 11'd1;
          end
        end
      end

      ST_ROUND_WON: begin
        if (frame_tick) begin
          if (win_cnt_q == WIN_W'(WIN_FRAMES - 1)) begin
            win_cnt_d    = '0;
            target_req_d = 1'b1;
            state_d      = ST_WAIT_TARGET;
          end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
          end
        end
      end

      ST_GAME_OVER: begin
        if (start_edge) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        target_req_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset parks the target at screen centre.
  always_ff @(posedge clk_25mHz or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      screen_end_q  <= 1'b0;
      start_q       <= 1'b0;
      target_req_q  <= 1'b0;
      target_x_q    <= 10'(X_CENTRE);
      target_y_q    <= 10'(Y_CENTRE);
      score_q       <= 8'd0;
      frames_left_q <= 11'd0;
      hold_count_q  <= 7'd0;
      win_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      screen_end_q  <= screen_end_d;
      start_q       <= start_d;
      target_req_q  <= target_req_d;
      target_x_q    <= target_x_d;
      target_y_q    <= target_y_d;
      score_q       <= score_d;
      frames_left_q <= frames_left_d;
      hold_count_q  <= hold_count_d;
      win_cnt_q     <= win_cnt_d;
    end
  end

  assign bus.game_state  = {29'd0, state_q};
  assign bus.target_req  = target_req_q;
  assign bus.target_x    = {22'd0, target_x_q};
  assign bus.target_y    = {22'd0, target_y_q};
  assign bus.score       = score_q;
  assign bus.frames_left = frames_left_q;
  assign bus.hold_count  = hold_count_q;

endmodule

// File: tb/tb_game_round_controller.sv
// Scoreboard bench: stimulus queues expected output snapshots, a negedge monitor
// pops one whenever state/target/request/score/hold of a DUT changes.
// dut_m runs default timing; dut_s runs a 10-frame game timer.
module tb_game_round_controller;

  localparam int HOLD = 60;
  localparam int WINF = 30;

  logic        clk = 1'b0;
  logic        rst_m = 1'b1;
  logic        rst_s = 1'b1;
  logic        screen_end = 1'b0;
  logic        start = 1'b0;
  logic        rand_valid = 1'b0;
  logic [31:0] acc_x = 32'd0;
  logic [31:0] acc_y = 32'd0;
  logic [9:0]  rnd_x = 10'd0;
  logic [8:0]  rnd_y = 9'd0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  game_round_controller_if ifm ();
  game_round_controller_if ifs ();

  assign ifm.screenEnd  = screen_end;
  assign ifm.start      = start;
  assign ifm.accel_x    = acc_x;
  assign ifm.accel_y    = acc_y;
  assign ifm.rand_x     = rnd_x;
  assign ifm.rand_y     = rnd_y;
  assign ifm.rand_valid = rand_valid;
  assign ifs.screenEnd  = screen_end;
  assign ifs.start      = start;
  assign ifs.accel_x    = acc_x;
  assign ifs.accel_y    = acc_y;
  assign ifs.rand_x     = rnd_x;
  assign ifs.rand_y     = rnd_y;
  assign ifs.rand_valid = rand_valid;

  game_round_controller dut_m (.clk_25mHz(clk), .reset(rst_m), .bus(ifm));
  game_round_controller #(.GAME_FRAMES(10)) dut_s (.clk_25mHz(clk), .reset(rst_s), .bus(ifs));

  typedef struct packed {
    logic [31:0] st;
    logic        req;
    logic [31:0] tx;
    logic [31:0] ty;
    logic [7:0]  sc;
    logic [10:0] fl;
    logic [6:0]  h;
  } snap_t;

  snap_t qm[$];
  snap_t qs[$];
  string qmn[$];
  string qsn[$];
  snap_t got_m, got_s, prev_m, prev_s;
  bit    seen_m = 1'b0;
  bit    seen_s = 1'b0;

  function automatic snap_t keyof(input snap_t s);
    snap_t k;
    k    = s;
    k.fl = '0;
    return k;
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("st=%0d req=%0d tx=%0d ty=%0d sc=%0d fl=%0d h=%0d",
                     s.st, s.req, s.tx, s.ty, s.sc, s.fl, s.h);
  endfunction

  task automatic check(input bit s, input snap_t got);
    snap_t e;
    string n;
    n_cmp++;
    if ((s && qs.size() == 0) || (!s && qm.size() == 0)) begin
      n_bad++;
      $display("FAIL %s unexpected_event: actual %s, required no change",
               s ? "short" : "main", fmt(got));
      return;
    end
    if (s) begin
      e = qs.pop_front();
      n = qsn.pop_front();
    end else begin
      e = qm.pop_front();
      n = qmn.pop_front();
    end
    if (got !== e) begin
      n_bad++;
      $display("FAIL %s.%s: actual %s, required %s", s ? "short" : "main", n, fmt(got), fmt(e));
    end
  endtask

  // Monitor: compare on every change of the observed key fields.
  always @(negedge clk) begin
    got_m = {ifm.game_state, ifm.target_req, ifm.target_x, ifm.target_y,
             ifm.score, ifm.frames_left, ifm.hold_count};
    got_s = {ifs.game_state, ifs.target_req, ifs.target_x, ifs.target_y,
             ifs.score, ifs.frames_left, ifs.hold_count};
    if (!seen_m || keyof(got_m) != keyof(prev_m)) check(1'b0, got_m);
    if (!seen_s || keyof(got_s) != keyof(prev_s)) check(1'b1, got_s);
    seen_m = 1'b1;
    seen_s = 1'b1;
    prev_m = got_m;
    prev_s = got_s;
  end

  task automatic ex(input bit s, input string n, input int st, input int req, input int tx,
                    input int ty, input int sc, input int fl, input int h);
    snap_t e;
    e.st  = st;
    e.req = req[0];
    e.tx  = tx;
    e.ty  = ty;
    e.sc  = sc[7:0];
    e.fl  = fl[10:0];
    e.h   = h[6:0];
    if (s) begin
      qs.push_back(e);
      qsn.push_back(n);
    end else begin
      qm.push_back(e);
      qmn.push_back(n);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame();
    screen_end = 1'b1;
    cycles(1);
    screen_end = 1'b0;
    cycles(3);
  endtask

  task automatic player(input int x, input int y);
    acc_x = x;
    acc_y = y;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
    cycles(2);
  endtask

  task automatic set_target(input int x, input int y);
    rnd_x      = x[9:0];
    rnd_y      = y[8:0];
    rand_valid = 1'b1;
    cycles(1);
    rand_valid = 1'b0;
    cycles(2);
  endtask

  // Player already placed inside the target; HOLD contained ticks end in a win.
  task automatic hold_round(input bit s, input string n, input int tx, input int ty,
                            input int sc, input int fl);
    for (int i = 1; i < HOLD; i++) begin
      ex(s, $sformatf("%s_h%0d", n, i), 2, 0, tx, ty, sc, fl - i, i);
      frame();
    end
    ex(s, {n, "_win"}, 3, 0, tx, ty, sc + 1, fl - (HOLD - 1), HOLD);
    frame();
  endtask

  task automatic win_wait(input bit s, input string n, input int tx, input int ty,
                          input int sc, input int fl);
    ex(s, n, 1, 1, tx, ty, sc, fl, HOLD);
    repeat (WINF) frame();
  endtask

  initial begin
    ex(0, "m_reset", 0, 0, 320, 240, 0, 0, 0);
    ex(1, "s_reset", 0, 0, 320, 240, 0, 0, 0);
    cycles(3);

    // Short game timer: expires after 10 uncontained ticks.
    rst_s = 1'b0;
    cycles(2);
    ex(1, "s_start", 1, 1, 320, 240, 0, 10, 0);
    pulse_start();
    ex(1, "s_target", 2, 0, 100, 200, 0, 10, 0);
    set_target(100, 200);
    player(0, 0);
    ex(1, "s_game_over", 4, 0, 100, 200, 0, 0, 0);
    repeat (10) frame();
    ex(1, "s_to_idle", 0, 0, 100, 200, 0, 0, 0);
    pulse_start();
    ex(1, "s_reset2", 0, 0, 320, 240, 0, 0, 0);
    rst_s = 1'b1;
    cycles(2);

    // Main DUT: start, first target, broken hold, first win.
    rst_m = 1'b0;
    cycles(2);
    ex(0, "start", 1, 1, 320, 240, 0, 1800, 0);
    pulse_start();
    ex(0, "target_100_200", 2, 0, 100, 200, 0, 1800, 0);
    set_target(100, 200);
    player(105, 195);
    for (int i = 1; i <= 58; i++) begin
      ex(0, $sformatf("pre_h%0d", i), 2, 0, 100, 200, 0, 1800 - i, i);
      frame();
    end
    player(106, 200);
    ex(0, "edge_6px_out", 2, 0, 100, 200, 0, 1741, 0);
    frame();
    player(105, 195);
    hold_round(0, "r1", 100, 200, 0, 1741);
    win_wait(0, "r1_next_req", 100, 200, 1, 1682);

    // Clamped target, then two more rounds to reach score 3.
    ex(0, "clamp_700_3", 2, 0, 609, 30, 1, 1682, 0);
    set_target(700, 3);
    player(609, 30);
    hold_round(0, "r2", 609, 30, 1, 1682);
    win_wait(0, "r2_next_req", 609, 30, 2, 1623);
    ex(0, "target_200_100", 2, 0, 200, 100, 2, 1623, 0);
    set_target(200, 100);
    player(200, 100);
    hold_round(0, "r3", 200, 100, 2, 1623);
    win_wait(0, "r3_next_req", 200, 100, 3, 1564);
    ex(0, "target_400_300", 2, 0, 400, 300, 3, 1564, 0);
    set_target(400, 300);
    player(400, 300);
    for (int i = 1; i <= 3; i++) begin
      ex(0, $sformatf("r4_h%0d", i), 2, 0, 400, 300, 3, 1564 - i, i);
      frame();
    end

    // Reset mid-PLAYING.
    ex(0, "mid_reset", 0, 0, 320, 240, 0, 0, 0);
    rst_m = 1'b1;
    cycles(1);
    rst_m = 1'b0;
    cycles(2);

    // Win on the same tick the timer would expire.
    ex(0, "g2_start", 1, 1, 320, 240, 0, 1800, 0);
    pulse_start();
    ex(0, "g2_target", 2, 0, 300, 200, 0, 1800, 0);
    set_target(300, 200);
    player(0, 0);
    repeat (1000) frame();
    pulse_start();
    set_target(10, 10);
    repeat (740) frame();
    player(300, 200);
    hold_round(0, "g2", 300, 200, 0, 60);
    win_wait(0, "g2_next_req", 300, 200, 1, 1);
    ex(0, "g2_target2", 2, 0, 50, 50, 1, 1, 0);
    set_target(50, 50);
    player(0, 0);
    ex(0, "g2_game_over", 4, 0, 50, 50, 1, 0, 0);
    frame();
    ex(0, "g2_idle_keeps_score", 0, 0, 50, 50, 1, 0, 0);
    pulse_start();
    cycles(5);

    while (qm.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL main.%s missing_event: actual none, required %s", qmn.pop_front(), fmt(qm.pop_front()));
    end
    while (qs.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL short.%s missing_event: actual none, required %s", qsn.pop_front(), fmt(qs.pop_front()));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
